// File: rtl/lpr_pkg.sv
// Shared types and constants for the plate-recognition run controller.
package lpr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DISPLAY,
        S_ERROR
    } lpr_state_t;

    localparam int CH_W = 6;
    localparam logic [CH_W-1:0] BLANK_CODE = 6'd0;
    localparam logic [CH_W-1:0] ERR_CODE   = 6'd63;

    // Wide enough for 0..MAX_CHARS with MAX_CHARS up to 7.
    typedef logic [2:0] char_count_t;

endpackage

// File: rtl/lpr_dwell_tick.sv
// Cycle tick generator: pulses tick for one cycle every CYCLES clocks after a
// synchronous clear; the count wraps to 0 on its terminal value.
module lpr_dwell_tick #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST) && !clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/lpr_run_controller.sv
// Sequences one plate-recognition run: start pulse, character capture, then
// cycling display on led. Optional RUN watchdog enabled by LPR_TIMEOUT_EN.
module lpr_run_controller
    import lpr_pkg::*;
#(
    parameter int MAX_CHARS      = 7,
    parameter int DWELL_CYCLES   = 66000000,
    parameter int TIMEOUT_CYCLES = 33000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    output logic            lp_start,
    input  logic            lp_char_valid,
    input  logic [CH_W-1:0] lp_char,
    input  logic            lp_done,
    output logic [CH_W-1:0] led,
    output logic            busy,
    output logic            result_valid,
    output logic [2:0]      char_count,
    output logic            overflow,
    output logic            timeout
);

    localparam char_count_t MAX_CNT = char_count_t'(MAX_CHARS);

    lpr_state_t      state;
    logic [CH_W-1:0] char_buf [MAX_CHARS];
    char_count_t     disp_idx;
    logic            dwell_tick;
    logic            start_req;

    // go is honoured only from the idle-like states; RUN ignores it.
    assign start_req = go && (state == S_IDLE || state == S_DISPLAY || state == S_ERROR);

    lpr_dwell_tick #(
        .CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clear(state != S_DISPLAY),
        .tick (dwell_tick)
    );

`ifdef LPR_TIMEOUT_EN
    logic wd_tick;
    logic timeout_flag;

    lpr_dwell_tick #(
        .CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk  (clk),
        .rst  (rst),
        .clear(state != S_RUN),
        .tick (wd_tick)
    );

    assign timeout = timeout_flag;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            lp_start     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            char_count   <= '0;
            led          <= BLANK_CODE;
            disp_idx     <= '0;
            for (int i = 0; i < MAX_CHARS; i++)
                char_buf[i] <= BLANK_CODE;
`ifdef LPR_TIMEOUT_EN
            timeout_flag <= 1'b0;
`endif
        end else begin
            lp_start <= 1'b0;
            if (start_req) begin
                state        <= S_START;
                lp_start     <= 1'b1;
                busy         <= 1'b1;
                result_valid <= 1'b0;
                overflow     <= 1'b0;
                char_count   <= '0;
                for (int i = 0; i < MAX_CHARS; i++)
                    char_buf[i] <= BLANK_CODE;
`ifdef LPR_TIMEOUT_EN
                timeout_flag <= 1'b0;
`endif
            end else begin
                case (state)
                    S_START: state <= S_RUN;
                    S_RUN: begin
                        if (lp_char_valid) begin
                            if (char_count < MAX_CNT) begin
                                char_buf[char_count] <= lp_char;
                                char_count           <= char_count + 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        // lp_done takes priority over a watchdog expiry in the same cycle.
                        if (lp_done) begin
                            state        <= S_DISPLAY;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            disp_idx     <= '0;
                        end
`ifdef LPR_TIMEOUT_EN
                        else if (wd_tick) begin
                            state        <= S_ERROR;
                            busy         <= 1'b0;
                            timeout_flag <= 1'b1;
                            led          <= ERR_CODE;
                        end
`endif
                    end
                    S_DISPLAY: begin
                        if (char_count == '0)
                            led <= BLANK_CODE;
                        else
                            led <= char_buf[disp_idx];
                        if (dwell_tick && char_count != '0)
                            disp_idx <= (disp_idx == char_count - 1'b1) ? '0 : disp_idx + 1'b1;
                    end
                    S_IDLE, S_ERROR: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpr_run_controller.sv
// Directed self-checking bench for lpr_run_controller (DWELL_CYCLES=4,
// TIMEOUT_CYCLES=20); watchdog scenario is exercised when LPR_TIMEOUT_EN is set.
module tb_lpr_run_controller;
    import lpr_pkg::*;

    localparam int MAX_CHARS = 7;
    localparam int DWELL     = 4;
    localparam int TIMEOUT   = 20;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            go = 1'b0;
    logic            lp_start;
    logic            lp_char_valid = 1'b0;
    logic [CH_W-1:0] lp_char = '0;
    logic            lp_done = 1'b0;
    logic [CH_W-1:0] led;
    logic            busy;
    logic            result_valid;
    logic [2:0]      char_count;
    logic            overflow;
    logic            timeout;

    int check_count = 0;
    int pass_count  = 0;
    int start_seen;
    logic [CH_W-1:0] basic_seq [4] = '{6'h0A, 6'h0B, 6'h0C, 6'h0A};

    lpr_run_controller #(
        .MAX_CHARS     (MAX_CHARS),
        .DWELL_CYCLES  (DWELL),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .go           (go),
        .lp_start     (lp_start),
        .lp_char_valid(lp_char_valid),
        .lp_char      (lp_char),
        .lp_done      (lp_done),
        .led          (led),
        .busy         (busy),
        .result_valid (result_valid),
        .char_count   (char_count),
        .overflow     (overflow),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // One cycle: inputs set now are sampled at the coming edge; outputs are read 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        check_output("start_pulse", lp_start, 1'b1);
        check_output("start_busy", busy, 1'b1);
        check_output("start_rv_low", result_valid, 1'b0);
        check_output("start_count_clr", char_count, 3'd0);
        tick();
        check_output("start_pulse_end", lp_start, 1'b0);
    endtask

    task automatic send_char(input logic [CH_W-1:0] code);
        lp_char_valid = 1'b1;
        lp_char       = code;
        tick();
        lp_char_valid = 1'b0;
    endtask

    task automatic finish_run();
        lp_done = 1'b1;
        tick();
        lp_done = 1'b0;
        check_output("done_rv", result_valid, 1'b1);
        check_output("done_busy", busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_lp_start", lp_start, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_rv", result_valid, 1'b0);
        check_output("rst_led", led, 6'd0);
        check_output("rst_count", char_count, 3'd0);
        check_output("rst_overflow", overflow, 1'b0);
        check_output("rst_timeout", timeout, 1'b0);
        rst = 1'b0;

        // Basic run: chars at cycles 3,5,7, done at 9, dwell of 4.
        start_run();
        tick();
        send_char(6'h0A);
        tick();
        send_char(6'h0B);
        tick();
        send_char(6'h0C);
        tick();
        finish_run();
        check_output("basic_count", char_count, 3'd3);
        start_seen = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            check_output("basic_led", led, basic_seq[k / 4]);
            if (lp_start) start_seen++;
        end
        check_output("basic_no_extra_start", start_seen, 0);

        // Overflow: eight characters into a seven-entry buffer.
        start_run();
        for (int c = 1; c <= 7; c++) send_char(CH_W'(c));
        check_output("ovf_before", overflow, 1'b0);
        check_output("ovf_count7", char_count, 3'd7);
        send_char(6'd8);
        check_output("ovf_set", overflow, 1'b1);
        check_output("ovf_count_hold", char_count, 3'd7);
        finish_run();
        for (int k = 0; k < 28; k++) begin
            tick();
            check_output("ovf_led", led, (k / 4) + 1);
        end
        tick();
        check_output("ovf_led_wrap", led, 6'd1);

        // Empty run; led holds its last value until the new DISPLAY.
        start_run();
        check_output("led_hold", led, 6'd1);
        finish_run();
        check_output("empty_count", char_count, 3'd0);
        check_output("empty_ovf_clr", overflow, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check_output("empty_led", led, BLANK_CODE);
        end

        // Character and lp_done in the same cycle.
        start_run();
        send_char(6'h11);
        lp_char_valid = 1'b1;
        lp_char       = 6'h15;
        finish_run();
        lp_char_valid = 1'b0;
        check_output("simul_count", char_count, 3'd2);
        for (int k = 0; k < 12; k++) begin
            tick();
            check_output("simul_led", led, ((k / 4) % 2 == 0) ? 6'h11 : 6'h15);
        end

        // Reset asserted mid-run after two characters.
        start_run();
        send_char(6'h21);
        send_char(6'h22);
        check_output("mid_count", char_count, 3'd2);
        #2 rst = 1'b1;
        #1;
        check_output("async_busy", busy, 1'b0);
        check_output("async_count", char_count, 3'd0);
        tick();
        check_output("mrst_led", led, 6'd0);
        check_output("mrst_rv", result_valid, 1'b0);
        check_output("mrst_start", lp_start, 1'b0);
        rst = 1'b0;
        start_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (lp_start) start_seen++;
        end
        check_output("no_start_after_rst", start_seen, 0);
        check_output("idle_busy", busy, 1'b0);

        // RUN without lp_done: watchdog behaviour depends on the build.
        start_run();
`ifdef LPR_TIMEOUT_EN
        repeat (TIMEOUT - 1) tick();
        check_output("wd_before", timeout, 1'b0);
        check_output("wd_busy_before", busy, 1'b1);
        tick();
        check_output("wd_timeout", timeout, 1'b1);
        check_output("wd_led", led, ERR_CODE);
        check_output("wd_busy", busy, 1'b0);
        go = 1'b1;
        tick();
        go = 1'b0;
        check_output("wd_clear", timeout, 1'b0);
        check_output("wd_restart", lp_start, 1'b1);
`else
        repeat (50) tick();
        check_output("no_wd_timeout", timeout, 1'b0);
        check_output("no_wd_busy", busy, 1'b1);
`endif

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
